// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (i_*) and the data-access port (d_*). One access is in flight at a
// time. The data port has priority, but after MAX_STREAK consecutive data
// grants taken while fetch was waiting, the next contested grant goes to
// fetch. The winning port gets a one-cycle ready pulse with its read data.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   i_req/i_addr        : fetch request and byte address
//   i_rdata/i_ready     : fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, store enable, address, data
//   d_rdata/d_ready     : load word and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory strobe and request
//   mem_rdata           : memory read data, valid LATENCY cycles after mem_en
//   misalign            : sticky flag for any granted misaligned request
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign
);

  localparam int STREAK_W = (MAX_STREAK < 4) ? 2 : (MAX_STREAK < 8) ? 3 : 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [3:0] LAT_LD = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                win_d, win_d_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;

  logic                mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic                i_ready_nxt, d_ready_nxt;
  logic [DATA_W-1:0]   i_rdata_nxt, d_rdata_nxt;
  logic                misalign_nxt;

  logic                pick_d;
  logic [ADDR_W-1:0]   sel_addr;

  // Saturating increment of the data-grant streak.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
  endfunction

  always_comb begin
    state_nxt     = state;
    win_d_nxt     = win_d;
    cnt_nxt       = cnt;
    streak_nxt    = streak;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    i_ready_nxt   = 1'b0;
    d_ready_nxt   = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    misalign_nxt  = misalign;
    pick_d        = d_req && (!i_req || (streak < STREAK_MAX));
    sel_addr      = pick_d ? d_addr : i_addr;

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          win_d_nxt = pick_d;
          // A data grant taken while fetch waits extends the streak;
          // any other grant ends it.
          if (pick_d && i_req) streak_nxt = streak_inc(streak);
          else                 streak_nxt = '0;

          if (sel_addr[1:0] != 2'b00) begin
            // Misaligned: no memory access, respond next cycle with zero.
            misalign_nxt = 1'b1;
            state_nxt    = RESP;
            if (pick_d) begin
              d_ready_nxt = 1'b1;
              d_rdata_nxt = '0;
            end else begin
              i_ready_nxt = 1'b1;
              i_rdata_nxt = '0;
            end
          end else begin
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = pick_d & d_we;
            mem_addr_nxt  = {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_nxt = d_wdata;
            cnt_nxt       = LAT_LD;
            state_nxt     = WAIT;
          end
        end
      end

      WAIT: begin
        // The count is measured from the mem_en cycle: it holds across that
        // cycle and reaches 1 in the cycle where mem_rdata is valid.
        if (!mem_en) cnt_nxt = cnt - 1'b1;
        if (!mem_en && (cnt == 4'd1)) begin
          state_nxt = RESP;
          if (win_d) begin
            d_ready_nxt = 1'b1;
            d_rdata_nxt = mem_rdata;
          end else begin
            i_ready_nxt = 1'b1;
            i_rdata_nxt = mem_rdata;
          end
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      win_d     <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      misalign  <= 1'b0;
    end else begin
      state     <= state_nxt;
      win_d     <= win_d_nxt;
      cnt       <= cnt_nxt;
      streak    <= streak_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      i_ready   <= i_ready_nxt;
      d_ready   <= d_ready_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      misalign  <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          misalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .MAX_STREAK(3)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words, read data valid LAT cycles after mem_en.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [LAT];
  logic          pre_we;
  logic [7:0]    pre_idx;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem[mem_addr[9:2]] : '0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (pre_we) mem[pre_idx] <= pre_data;
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [DW-1:0] val);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = val;
    tick();
    pre_we   = 1'b0;
  endtask

  logic [7:0] order;
  int         exp_streak;

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    for (int k = 0; k < LAT; k++) pipe[k] = '0;

    // Reset state
    tick(); tick();
    chk("rst_mem_en",    mem_en,    0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_ready",   i_ready,   0);
    chk("rst_d_ready",   d_ready,   0);
    chk("rst_i_rdata",   i_rdata,   0);
    chk("rst_d_rdata",   d_rdata,   0);
    chk("rst_misalign",  misalign,  0);
    preload(8'h01, 32'h2010_0005);
    preload(8'h80, 32'h1234_5678);
    reset = 1'b0;
    tick();

    // Fetch only
    i_req = 1'b1; i_addr = 32'h0000_0004;
    tick();
    chk("f_c1_mem_en",   mem_en,   1);
    chk("f_c1_mem_we",   mem_we,   0);
    chk("f_c1_mem_addr", mem_addr, 32'h4);
    chk("f_c1_i_ready",  i_ready,  0);
    tick();
    chk("f_c2_mem_en",   mem_en,   0);
    tick();
    chk("f_c3_i_ready",  i_ready,  0);
    tick();
    chk("f_c4_i_ready",  i_ready,  1);
    chk("f_c4_i_rdata",  i_rdata,  32'h2010_0005);
    chk("f_c4_d_ready",  d_ready,  0);
    i_req = 1'b0;
    tick();
    chk("f_c5_i_ready",  i_ready,  0);
    chk("f_c5_i_hold",   i_rdata,  32'h2010_0005);

    // Store then load
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_mem_en",    mem_en,    1);
    chk("st_mem_we",    mem_we,    1);
    chk("st_mem_addr",  mem_addr,  32'h40);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_c2_mem_we", mem_we,    0);
    tick(); tick();
    chk("st_d_ready",   d_ready,   1);
    d_we = 1'b0;
    tick();
    chk("st_c5_d_ready", d_ready,  0);
    chk("st_c5_mem_en",  mem_en,   0);
    tick();
    chk("ld_mem_en",    mem_en,    1);
    chk("ld_mem_we",    mem_we,    0);
    chk("ld_mem_addr",  mem_addr,  32'h40);
    tick(); tick(); tick();
    chk("ld_d_ready",   d_ready,   1);
    chk("ld_d_rdata",   d_rdata,   32'hDEAD_BEEF);
    chk("ld_i_ready",   i_ready,   0);
    d_req = 1'b0;
    tick();

    // Contention: D,D,D,I,D,D,D,I (bit set = data grant)
    order = 8'b0111_0111;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int g = 0; g < 8; g++) begin
      exp_streak = ((g % 4) == 3) ? 0 : (g % 4) + 1;
      tick();
      chk("ct_mem_en",   mem_en,   1);
      chk("ct_mem_addr", mem_addr, order[g] ? 32'h200 : 32'h100);
      chk("ct_streak",   64'(dut.streak), 64'(exp_streak));
      tick(); tick(); tick();
      chk("ct_d_ready",  d_ready,  order[g] ? 1 : 0);
      chk("ct_i_ready",  i_ready,  order[g] ? 0 : 1);
      if (g == 7) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      tick();
    end
    chk("ct_d_rdata", d_rdata, 32'h1234_5678);

    // Misaligned data request
    chk("ma_before", misalign, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h42;
    tick();
    chk("ma_mem_en",   mem_en,   0);
    chk("ma_d_ready",  d_ready,  1);
    chk("ma_d_rdata",  d_rdata,  0);
    chk("ma_flag",     misalign, 1);
    d_req = 1'b0;
    tick();
    chk("ma_c2_mem_en",  mem_en,  0);
    chk("ma_c2_d_ready", d_ready, 0);

    // Dropped request, then earliest next access
    d_req = 1'b1; d_addr = 32'h40;
    tick();
    chk("dr_mem_en", mem_en, 1);
    tick();
    d_req = 1'b0;
    tick(); tick();
    chk("dr_d_ready",  d_ready,  1);
    chk("dr_d_rdata",  d_rdata,  32'hDEAD_BEEF);
    chk("dr_misalign", misalign, 1);
    d_req = 1'b1; d_addr = 32'h200;
    tick();
    chk("dr_c5_mem_en",  mem_en,  0);
    chk("dr_c5_d_ready", d_ready, 0);
    tick();
    chk("dr_c6_mem_en",   mem_en,   1);
    chk("dr_c6_mem_addr", mem_addr, 32'h200);
    d_req = 1'b0;
    tick(); tick(); tick();
    chk("dr2_d_ready", d_ready, 1);
    chk("dr2_d_rdata", d_rdata, 32'h1234_5678);
    tick();

    // Reset in the middle of a fetch wait
    i_req = 1'b1; i_addr = 32'h4;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rw_mem_en",   mem_en,   0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_i_rdata",  i_rdata,  0);
    chk("rw_d_rdata",  d_rdata,  0);
    chk("rw_misalign", misalign, 0);
    i_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rw_no_i_ready", i_ready, 0);
      chk("rw_no_mem_en",  mem_en,  0);
    end
    i_req = 1'b1; i_addr = 32'h4;
    tick();
    chk("rf_mem_en", mem_en, 1);
    tick(); tick();
    chk("rf_c3_i_ready", i_ready, 0);
    tick();
    chk("rf_i_ready", i_ready, 1);
    chk("rf_i_rdata", i_rdata, 32'h2010_0005);
    i_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
